fetch_ctrl: RTL and testbench

//  Fetch sequencer: owns the fetch PC and issues reads to the 1-cycle-latency instruction ROM.

---
 rtl/fetch_ctrl_if.sv | 26 ++
 rtl/fetch_ctrl.sv | 112 +++++++++++
 tb/tb_fetch_ctrl.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: ROM read port, redirect input and decode handshake bundled together.
// Latency: wires only, no storage.
// Backpressure: out_ready from decode stalls the fetch-queue head; no ROM-side backpressure.
interface fetch_ctrl_if;
    logic        irom_en;
    logic [31:0] irom_addr;
    logic [31:0] irom_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_ready;

    // Fetch sequencer side: drives ROM requests and the decode-facing head.
    modport master (
        output irom_en, irom_addr, out_valid, out_pc, out_inst,
        input  irom_data, redirect_valid, redirect_pc, out_ready
    );

    // Environment side: ROM, back end and decode.
    modport slave (
        input  irom_en, irom_addr, out_valid, out_pc, out_inst,
        output irom_data, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: owns the fetch PC, reads the 1-cycle ROM, buffers results in a FQ_DEPTH-entry queue for decode.
// Latency: instruction visible on out_* 2 cycles after issue; redirect target visible 3 cycles after redirect.
// Backpressure: issue is credit-gated on occupancy + in-flight read; out_ready stalls the head. Option macro FETCH_PERF_EN.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          FQ_DEPTH = 4
) (
    input  logic         clock,
    input  logic         reset,
    fetch_ctrl_if.master bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]  perf_fetch_cnt,
    output logic [31:0]  perf_flush_cnt
`endif
);
    localparam int PW = $clog2(FQ_DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   tag_pc;
    logic          inflight;
    logic [CW-1:0] count;
    logic [CW-1:0] occ_total;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   pc_mem   [FQ_DEPTH];
    logic [31:0]   inst_mem [FQ_DEPTH];
    logic          issue;
    logic          push;
    logic          pop;
    logic          head_vld;

    // Target addresses are word aligned; the low redirect bits carry no meaning.
    wire unused_redirect_lsbs = ^bus.redirect_pc[1:0];

    // Credit check counts the in-flight read so a returning response always has a slot.
    // A redirect kills the issue, the returning response and any pop in the same cycle.
    always_comb begin
        occ_total = count + CW'(inflight);
        head_vld  = (count != '0) && !reset;
        issue     = !reset && !bus.redirect_valid && (occ_total < CW'(FQ_DEPTH));
        push      = inflight && !bus.redirect_valid;
        pop       = head_vld && bus.out_ready && !bus.redirect_valid;
    end

    assign bus.irom_en   = issue;
    assign bus.irom_addr = fetch_pc;
    assign bus.out_valid = head_vld;
    assign bus.out_pc    = pc_mem[rd_ptr];
    assign bus.out_inst  = inst_mem[rd_ptr];

    // PC sequencing, in-flight tracking and queue pointers; reset beats redirect beats normal flow.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc <= {RESET_PC[31:2], 2'b00};
            tag_pc   <= {RESET_PC[31:2], 2'b00};
            inflight <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else if (bus.redirect_valid) begin
            fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
            inflight <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                tag_pc   <= fetch_pc;
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Queue storage: the ROM response is written together with the PC it was fetched from.
    always_ff @(posedge clock) begin
        if (push && !reset) begin
            pc_mem[wr_ptr]   <= tag_pc;
            inst_mem[wr_ptr] <= bus.irom_data;
        end
    end

`ifdef FETCH_PERF_EN
    // Consumed-instruction and flush counters; both wrap freely.
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_fetch_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (pop) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (bus.redirect_valid) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed stimulus against a queue-based model of the fetch sequencer.
// The model tracks fetch PC, one pending ROM read and a list of buffered {pc, inst} entries.
// A ROM model answers every request one cycle later with a PC-derived instruction word.
module tb_fetch_ctrl;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h8000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic clock = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    fetch_ctrl_if bus ();

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    fetch_ctrl #(.RESET_PC(RPC), .FQ_DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] rom_fn(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ROM: captures the request mid-cycle, presents data just after the next edge.
    initial begin
        logic        en_s;
        logic [31:0] addr_s;
        bus.irom_data = 32'h0;
        forever begin
            @(negedge clock);
            en_s   = bus.irom_en;
            addr_s = bus.irom_addr;
            @(posedge clock);
            #1;
            bus.irom_data = en_s ? rom_fn(addr_s) : 32'hDEAD_BEEF;
        end
    end

    // Model + compare, once per cycle at the falling edge.
    ent_t        mq[$];
    logic [31:0] m_pc  = RPC;
    logic [31:0] m_tag = RPC;
    bit          m_infl = 1'b0;
`ifdef FETCH_PERF_EN
    logic [31:0] m_fetch = 32'h0;
    logic [31:0] m_flush = 32'h0;
`endif

    initial begin
        bit   exp_en;
        bit   exp_vld;
        ent_t e;
        forever begin
            @(negedge clock);
            exp_en  = !reset && !bus.redirect_valid && (mq.size() + int'(m_infl) < DEPTH);
            exp_vld = !reset && (mq.size() != 0);
            chk("irom_en", 32'(bus.irom_en), 32'(exp_en));
            if (exp_en) chk("irom_addr", bus.irom_addr, m_pc);
            chk("out_valid", 32'(bus.out_valid), 32'(exp_vld));
            if (exp_vld) begin
                chk("out_pc", bus.out_pc, mq[0].pc);
                chk("out_inst", bus.out_inst, mq[0].inst);
            end
`ifdef FETCH_PERF_EN
            chk("perf_fetch", perf_fetch_cnt, m_fetch);
            chk("perf_flush", perf_flush_cnt, m_flush);
`endif
            if (reset) begin
                mq.delete();
                m_infl = 1'b0;
                m_pc   = RPC;
`ifdef FETCH_PERF_EN
                m_fetch = 32'h0;
                m_flush = 32'h0;
`endif
            end else if (bus.redirect_valid) begin
                mq.delete();
                m_infl = 1'b0;
                m_pc   = {bus.redirect_pc[31:2], 2'b00};
`ifdef FETCH_PERF_EN
                m_flush = m_flush + 32'd1;
`endif
            end else begin
                if (exp_vld && bus.out_ready) begin
                    void'(mq.pop_front());
`ifdef FETCH_PERF_EN
                    m_fetch = m_fetch + 32'd1;
`endif
                end
                if (m_infl) begin
                    e.pc   = m_tag;
                    e.inst = rom_fn(m_tag);
                    mq.push_back(e);
                end
                m_infl = exp_en;
                if (exp_en) begin
                    m_tag = m_pc;
                    m_pc  = m_pc + 32'd4;
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic mid();
        @(negedge clock);
    endtask

    task automatic redirect_to(input logic [31:0] tgt);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = tgt;
        mid();
        chk("redir_no_issue", 32'(bus.irom_en), 32'h0);
        step();
        bus.redirect_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] pat;
        reset              = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.out_ready      = 1'b1;

        // Reset state, then release with decode ready.
        step();
        mid();
        chk("rst_en", 32'(bus.irom_en), 32'h0);
        chk("rst_vld", 32'(bus.out_valid), 32'h0);
        step();
        reset = 1'b0;
        mid();
        chk("t1_en0", 32'(bus.irom_en), 32'h1);
        chk("t1_addr0", bus.irom_addr, 32'h8000_0000);
        chk("t1_vld0", 32'(bus.out_valid), 32'h0);
        step(); mid();
        chk("t1_addr1", bus.irom_addr, 32'h8000_0004);
        step(); mid();
        chk("t1_vld2", 32'(bus.out_valid), 32'h1);
        chk("t1_pc2", bus.out_pc, 32'h8000_0000);
        chk("t1_inst2", bus.out_inst, rom_fn(32'h8000_0000));
        step(); mid();
        chk("t1_pc3", bus.out_pc, 32'h8000_0004);
        repeat (4) step();

        // Stall decode from reset: exactly four fetches, then drain in order.
        reset = 1'b1;
        bus.out_ready = 1'b0;
        step();
        reset = 1'b0;
        repeat (10) step();
        mid();
        chk("t2_full_en", 32'(bus.irom_en), 32'h0);
        chk("t2_head", bus.out_pc, 32'h8000_0000);
        step();
        bus.out_ready = 1'b1;
        mid();
        chk("t2_pc0", bus.out_pc, 32'h8000_0000);
        step(); mid();
        chk("t2_pc1", bus.out_pc, 32'h8000_0004);
        chk("t2_resume_en", 32'(bus.irom_en), 32'h1);
        chk("t2_resume_addr", bus.irom_addr, 32'h8000_0010);
        step(); mid();
        chk("t2_pc2", bus.out_pc, 32'h8000_0008);
        step(); mid();
        chk("t2_pc3", bus.out_pc, 32'h8000_000C);
        repeat (3) step();

        // Redirect with a response in flight; stale data must never surface.
        redirect_to(32'h8000_1002);
        mid();
        chk("t3_vld1", 32'(bus.out_valid), 32'h0);
        step(); mid();
        chk("t3_vld2", 32'(bus.out_valid), 32'h0);
        step(); mid();
        chk("t3_vld3", 32'(bus.out_valid), 32'h1);
        chk("t3_pc3", bus.out_pc, 32'h8000_1000);
        repeat (3) step();

        // Redirect in the same cycle as a handshake: head dropped, queue empty next cycle.
        mid();
        chk("t4_vld_pre", 32'(bus.out_valid), 32'h1);
        step();
        redirect_to(32'h8000_2000);
        mid();
        chk("t4_empty", 32'(bus.out_valid), 32'h0);
        step(); step(); mid();
        chk("t4_pc", bus.out_pc, 32'h8000_2000);
        repeat (2) step();

        // Back-to-back redirects: the second target wins.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h9000_0000;
        step();
        redirect_to(32'h9000_1004);
        mid();
        chk("bb_vld1", 32'(bus.out_valid), 32'h0);
        step(); mid();
        chk("bb_vld2", 32'(bus.out_valid), 32'h0);
        step(); mid();
        chk("bb_pc", bus.out_pc, 32'h9000_1004);
        repeat (2) step();

        // Address wrap at the top of the 32-bit space.
        redirect_to(32'hFFFF_FFF8);
        step(); step(); mid();
        chk("t5_pc0", bus.out_pc, 32'hFFFF_FFF8);
        step(); mid();
        chk("t5_pc1", bus.out_pc, 32'hFFFF_FFFC);
        step(); mid();
        chk("t5_pc2", bus.out_pc, 32'h0000_0000);
        step();

        // Irregular decode backpressure, checked cycle by cycle by the model.
        pat = 32'hB3C5_0F96;
        for (int i = 0; i < 32; i++) begin
            bus.out_ready = pat[i];
            step();
        end

        // Reset with a full queue mid-stream.
        bus.out_ready = 1'b0;
        repeat (8) step();
        mid();
        chk("t6_full_en", 32'(bus.irom_en), 32'h0);
        step();
        reset = 1'b1;
        bus.out_ready = 1'b1;
        mid();
        chk("t6_rst_vld", 32'(bus.out_valid), 32'h0);
        step();
        reset = 1'b0;
        mid();
        chk("t6_vld", 32'(bus.out_valid), 32'h0);
        chk("t6_en", 32'(bus.irom_en), 32'h1);
        chk("t6_addr", bus.irom_addr, 32'h8000_0000);
`ifdef FETCH_PERF_EN
        chk("t6_perf_fetch", perf_fetch_cnt, 32'h0);
        chk("t6_perf_flush", perf_flush_cnt, 32'h0);
`endif
        step(); step(); mid();
        chk("t6_pc", bus.out_pc, 32'h8000_0000);
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
